// File: rtl/spm_port_arbiter.sv
// rtl/spm_port_arbiter.sv - two-master arbiter for the scratchpad MEM-side port (Port B)
//
// Shares SPM Port B between M0 (CPU MEM stage) and M1 (bus loader/DMA).
// One access is issued per cycle. Completion and read data return the
// cycle after issue. M0 has priority unless M1 has been denied MAX_WAIT
// consecutive cycles.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   m0_req/addr/rw/wr_data   M0 request (rw: 1=read, 0=write)
//   m0_rd_data, m0_rdy       M0 completion and read data
//   m1_*                     same as M0, for M1
//   spm_addr/as_n/rw/wr_data Port B request pins (as_n active low)
//   spm_rd_data              Port B read data, valid the cycle after strobe
module spm_port_arbiter #(
  parameter int SPM_ADDR_W = 12,
  parameter int WORD_W     = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic [SPM_ADDR_W-1:0] m0_addr,
  input  logic                  m0_rw,
  input  logic [WORD_W-1:0]     m0_wr_data,
  output logic [WORD_W-1:0]     m0_rd_data,
  output logic                  m0_rdy,
  input  logic                  m1_req,
  input  logic [SPM_ADDR_W-1:0] m1_addr,
  input  logic                  m1_rw,
  input  logic [WORD_W-1:0]     m1_wr_data,
  output logic [WORD_W-1:0]     m1_rd_data,
  output logic                  m1_rdy,
  output logic [SPM_ADDR_W-1:0] spm_addr,
  output logic                  spm_as_n,
  output logic                  spm_rw,
  output logic [WORD_W-1:0]     spm_wr_data,
  input  logic [WORD_W-1:0]     spm_rd_data
);

  localparam logic RW_READ = 1'b1;
  localparam logic [2:0] WAIT_LIMIT = 3'(MAX_WAIT);

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_M0   = 2'd1,
    PEND_M1   = 2'd2
  } pend_t;

  pend_t      pend_q;
  logic       pend_rd_q;
  logic [2:0] wait_cnt_q;
  logic       grant_m0;
  logic       grant_m1;

  // Priority to M0, except when M1 has already been denied MAX_WAIT times.
  always_comb begin
    grant_m0 = 1'b0;
    grant_m1 = 1'b0;
    if (!reset) begin
      if (m0_req && m1_req) begin
        if (wait_cnt_q == WAIT_LIMIT) grant_m1 = 1'b1;
        else                          grant_m0 = 1'b1;
      end else if (m0_req) begin
        grant_m0 = 1'b1;
      end else if (m1_req) begin
        grant_m1 = 1'b1;
      end
    end
  end

  // Port B is driven straight from the winner so the SPM samples it this edge.
  always_comb begin
    spm_as_n    = 1'b1;
    spm_addr    = '0;
    spm_rw      = RW_READ;
    spm_wr_data = '0;
    if (grant_m0) begin
      spm_as_n    = 1'b0;
      spm_addr    = m0_addr;
      spm_rw      = m0_rw;
      spm_wr_data = m0_wr_data;
    end else if (grant_m1) begin
      spm_as_n    = 1'b0;
      spm_addr    = m1_addr;
      spm_rw      = m1_rw;
      spm_wr_data = m1_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= PEND_NONE;
      pend_rd_q  <= RW_READ;
      wait_cnt_q <= 3'd0;
    end else begin
      if (grant_m0)      pend_q <= PEND_M0;
      else if (grant_m1) pend_q <= PEND_M1;
      else               pend_q <= PEND_NONE;
      pend_rd_q <= grant_m0 ? m0_rw : m1_rw;

      // Counts consecutive denied M1 cycles; any M1 grant or idle M1 clears it.
      if (grant_m1 || !m1_req)        wait_cnt_q <= 3'd0;
      else if (wait_cnt_q != WAIT_LIMIT) wait_cnt_q <= wait_cnt_q + 3'd1;
    end
  end

  // Completion is gated by reset so an access caught by reset never reports.
  always_comb begin
    m0_rdy     = !reset && (pend_q == PEND_M0);
    m1_rdy     = !reset && (pend_q == PEND_M1);
    m0_rd_data = (m0_rdy && pend_rd_q) ? spm_rd_data : '0;
    m1_rd_data = (m1_rdy && pend_rd_q) ? spm_rd_data : '0;
  end

endmodule

// File: tb/tb_spm_port_arbiter.sv
// tb/tb_spm_port_arbiter.sv - self-checking bench for spm_port_arbiter
module tb_spm_port_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_rw = 1'b1;
  logic [11:0] m0_addr = '0;
  logic [31:0] m0_wr_data = '0;
  logic [31:0] m0_rd_data;
  logic        m0_rdy;
  logic        m1_req = 1'b0, m1_rw = 1'b1;
  logic [11:0] m1_addr = '0;
  logic [31:0] m1_wr_data = '0;
  logic [31:0] m1_rd_data;
  logic        m1_rdy;
  logic [11:0] spm_addr;
  logic        spm_as_n;
  logic        spm_rw;
  logic [31:0] spm_wr_data;
  logic [31:0] spm_rd_data = '0;

  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] spm_mem [0:4095];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spm_port_arbiter #(.SPM_ADDR_W(12), .WORD_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_rw(m0_rw), .m0_wr_data(m0_wr_data),
    .m0_rd_data(m0_rd_data), .m0_rdy(m0_rdy),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_rw(m1_rw), .m1_wr_data(m1_wr_data),
    .m1_rd_data(m1_rd_data), .m1_rdy(m1_rdy),
    .spm_addr(spm_addr), .spm_as_n(spm_as_n), .spm_rw(spm_rw),
    .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data)
  );

  // Scratchpad Port B: samples on the strobed edge, read data next cycle.
  always @(posedge clk) begin
    if (pre_en) spm_mem[pre_addr] <= pre_data;
    if (!spm_as_n) begin
      if (spm_rw) spm_rd_data <= spm_mem[spm_addr];
      else        spm_mem[spm_addr] <= spm_wr_data;
    end
  end

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic test_reset();
    m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 12'h00a;
    m1_req = 1'b1; m1_rw = 1'b1; m1_addr = 12'h00b;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (spm_as_n !== 1'b1 || m0_rdy !== 1'b0 || m1_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle: as_n=%b m0_rdy=%b m1_rdy=%b expected 1/0/0", spm_as_n, m0_rdy, m1_rdy);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (spm_as_n !== 1'b0 || spm_addr !== 12'h00a) begin
      n_fail++;
      $display("FAIL reset_first_grant: as_n=%b addr=%h expected 0/00a", spm_as_n, spm_addr);
    end
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m0_rdy !== 1'b1 || m1_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_rdy: m0_rdy=%b m1_rdy=%b expected 1/0", m0_rdy, m1_rdy);
    end
  endtask

  task automatic test_m0_write_read();
    @(posedge clk); #1;
    m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 12'h000; m0_wr_data = 32'h1234;
    @(negedge clk);
    n_checks++;
    if (spm_as_n !== 1'b0 || spm_rw !== 1'b0 || spm_wr_data !== 32'h1234) begin
      n_fail++;
      $display("FAIL m0_write_issue: as_n=%b rw=%b wd=%h expected 0/0/00001234", spm_as_n, spm_rw, spm_wr_data);
    end
    @(posedge clk); #1;
    m0_rw = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m0_rdy !== 1'b1 || m0_rd_data !== 32'h0 || m1_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL m0_write_done: rdy=%b data=%h m1_rdy=%b expected 1/00000000/0", m0_rdy, m0_rd_data, m1_rdy);
    end
    @(posedge clk); #1;
    m0_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m0_rdy !== 1'b1 || m0_rd_data !== 32'h00001234 || m1_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL m0_read_back: rdy=%b data=%h m1_rdy=%b expected 1/00001234/0", m0_rdy, m0_rd_data, m1_rdy);
    end
  endtask

  task automatic test_m1_burst();
    for (int i = 1; i <= 4; i++) preload(12'(i), 32'hA0 + 32'(i));
    for (int i = 0; i <= 4; i++) begin
      @(posedge clk); #1;
      m1_req = (i < 4); m1_rw = 1'b1; m1_addr = 12'(i + 1);
      @(negedge clk);
      if (i < 4) begin
        n_checks++;
        if (spm_as_n !== 1'b0 || spm_addr !== 12'(i + 1)) begin
          n_fail++;
          $display("FAIL m1_burst_issue[%0d]: as_n=%b addr=%h expected 0/%h", i, spm_as_n, spm_addr, 12'(i + 1));
        end
      end
      if (i > 0) begin
        n_checks++;
        if (m1_rdy !== 1'b1 || m1_rd_data !== 32'hA0 + 32'(i) || m0_rdy !== 1'b0) begin
          n_fail++;
          $display("FAIL m1_burst_data[%0d]: rdy=%b data=%h m0_rdy=%b expected 1/%h/0", i, m1_rdy, m1_rd_data, m0_rdy, 32'hA0 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_starvation();
    bit exp_m1_grant, exp_m1_rdy;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 12'h100;
      m1_req = 1'b1; m1_rw = 1'b1; m1_addr = 12'h200;
      @(negedge clk);
      exp_m1_grant = (c % (MAX_WAIT + 1)) == 0;
      exp_m1_rdy   = (c > 1) && ((c - 1) % (MAX_WAIT + 1)) == 0;
      n_checks++;
      if (spm_as_n !== 1'b0 || spm_addr !== (exp_m1_grant ? 12'h200 : 12'h100)) begin
        n_fail++;
        $display("FAIL starve_grant[c%0d]: as_n=%b addr=%h expected m1_grant=%b", c, spm_as_n, spm_addr, exp_m1_grant);
      end
      n_checks++;
      if (m1_rdy !== exp_m1_rdy || m0_rdy !== (c > 1 && !exp_m1_rdy)) begin
        n_fail++;
        $display("FAIL starve_rdy[c%0d]: m0_rdy=%b m1_rdy=%b expected %b/%b", c, m0_rdy, m1_rdy, (c > 1 && !exp_m1_rdy), exp_m1_rdy);
      end
    end
    idle_cycle();
  endtask

  task automatic test_same_addr();
    preload(12'h010, 32'h0);
    @(posedge clk); #1;
    m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 12'h010; m0_wr_data = 32'hABCD;
    m1_req = 1'b1; m1_rw = 1'b1; m1_addr = 12'h010;
    @(negedge clk);
    n_checks++;
    if (spm_as_n !== 1'b0 || spm_rw !== 1'b0) begin
      n_fail++;
      $display("FAIL same_addr_m0_first: as_n=%b rw=%b expected 0/0", spm_as_n, spm_rw);
    end
    @(posedge clk); #1;
    m0_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m0_rdy !== 1'b1 || m1_rdy !== 1'b0 || spm_as_n !== 1'b0 || spm_rw !== 1'b1) begin
      n_fail++;
      $display("FAIL same_addr_m1_issue: m0_rdy=%b m1_rdy=%b as_n=%b rw=%b expected 1/0/0/1", m0_rdy, m1_rdy, spm_as_n, spm_rw);
    end
    @(posedge clk); #1;
    m1_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m1_rdy !== 1'b1 || m1_rd_data !== 32'h0000ABCD) begin
      n_fail++;
      $display("FAIL same_addr_m1_data: rdy=%b data=%h expected 1/0000abcd", m1_rdy, m1_rd_data);
    end
  endtask

  task automatic test_reset_mid_access();
    preload(12'h020, 32'h5A5A0020);
    preload(12'h030, 32'h11111111);
    @(posedge clk); #1;
    m1_req = 1'b1; m1_rw = 1'b1; m1_addr = 12'h020;
    @(posedge clk); #1;
    m1_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m1_rdy !== 1'b0 || m1_rd_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_in_rdy: rdy=%b data=%h expected 0/00000000", m1_rdy, m1_rd_data);
    end
    // Write presented while reset is high must never strobe.
    @(posedge clk); #1;
    m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 12'h030; m0_wr_data = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++;
    if (spm_as_n !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_issue: as_n=%b expected 1", spm_as_n);
    end
    @(posedge clk); #1;
    reset = 1'b0; m0_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m0_rdy !== 1'b0 || m1_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pend_cleared: m0_rdy=%b m1_rdy=%b expected 0/0", m0_rdy, m1_rdy);
    end
    @(posedge clk); #1;
    m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 12'h030;
    @(posedge clk); #1;
    m0_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m0_rdy !== 1'b1 || m0_rd_data !== 32'h11111111) begin
      n_fail++;
      $display("FAIL reset_no_write: rdy=%b data=%h expected 1/11111111", m0_rdy, m0_rd_data);
    end
  endtask

  // Random traffic against a transaction-level model: the grant is chosen from
  // the stated priority rule and a count of consecutive M1 denials, and read
  // results come from a reference copy of the touched memory.
  task automatic test_random();
    logic [31:0] ref_mem [0:7];
    bit          act [2];
    bit          rw [2];
    logic [11:0] addr [2];
    logic [31:0] wd [2];
    bit          exp_rdy [2];
    logic [31:0] exp_rd [2];
    int          denials = 0;
    int          g;
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = $urandom;
      preload(12'h040 + 12'(i), ref_mem[i]);
    end
    for (int m = 0; m < 2; m++) begin
      act[m] = 0; rw[m] = 1; addr[m] = '0; wd[m] = '0; exp_rdy[m] = 0; exp_rd[m] = '0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        if (exp_rdy[m]) act[m] = 0;
        else if (act[m] && $urandom_range(0, 15) == 0) act[m] = 0;
        if (!act[m] && $urandom_range(0, 2) != 0) begin
          act[m] = 1;
          rw[m] = $urandom_range(0, 1) == 1;
          addr[m] = 12'h040 + 12'($urandom_range(0, 7));
          wd[m] = $urandom;
        end
      end
      m0_req = act[0]; m0_rw = rw[0]; m0_addr = addr[0]; m0_wr_data = wd[0];
      m1_req = act[1]; m1_rw = rw[1]; m1_addr = addr[1]; m1_wr_data = wd[1];
      @(negedge clk);
      n_checks++;
      if (m0_rdy !== exp_rdy[0] || m0_rd_data !== exp_rd[0]) begin
        n_fail++;
        $display("FAIL rand_m0[cyc%0d]: rdy=%b data=%h expected %b/%h", cyc, m0_rdy, m0_rd_data, exp_rdy[0], exp_rd[0]);
      end
      n_checks++;
      if (m1_rdy !== exp_rdy[1] || m1_rd_data !== exp_rd[1]) begin
        n_fail++;
        $display("FAIL rand_m1[cyc%0d]: rdy=%b data=%h expected %b/%h", cyc, m1_rdy, m1_rd_data, exp_rdy[1], exp_rd[1]);
      end
      if (act[0] && act[1]) g = (denials >= MAX_WAIT) ? 1 : 0;
      else if (act[0])      g = 0;
      else if (act[1])      g = 1;
      else                  g = -1;
      n_checks++;
      if (g < 0) begin
        if (spm_as_n !== 1'b1 || spm_addr !== 12'h0 || spm_rw !== 1'b1 || spm_wr_data !== 32'h0) begin
          n_fail++;
          $display("FAIL rand_idle[cyc%0d]: as_n=%b addr=%h rw=%b wd=%h expected 1/000/1/00000000", cyc, spm_as_n, spm_addr, spm_rw, spm_wr_data);
        end
      end else if (spm_as_n !== 1'b0 || spm_addr !== addr[g] || spm_rw !== rw[g] || spm_wr_data !== wd[g]) begin
        n_fail++;
        $display("FAIL rand_grant[cyc%0d]: as_n=%b addr=%h rw=%b expected M%0d addr=%h rw=%b", cyc, spm_as_n, spm_addr, spm_rw, g, addr[g], rw[g]);
      end
      for (int m = 0; m < 2; m++) begin
        exp_rdy[m] = (g == m);
        exp_rd[m]  = '0;
      end
      if (g >= 0) begin
        if (rw[g]) exp_rd[g] = ref_mem[addr[g] - 12'h040];
        else       ref_mem[addr[g] - 12'h040] = wd[g];
      end
      if (act[1] && g != 1) denials = (denials < MAX_WAIT) ? denials + 1 : MAX_WAIT;
      else                  denials = 0;
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_m0_write_read();
    test_m1_burst();
    test_starvation();
    test_same_addr();
    test_reset_mid_access();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
